// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage: fetch FSM states, the
// canonical NOP used as the F/D clear value, and the datapath width.
package fetch_unit_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0; also the value the F/D register loads when flushed
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HELD = 2'd2,
    KILL = 2'd3
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_perf_ctr.sv
// Fetch performance counters: instructions handed to decode and fetches
// thrown away. Instantiated by fetch_unit only when FETCH_PERF_CNT_EN is defined.
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetched_i,
  input  logic        killed_i,
  output logic [31:0] fetched_o,
  output logic [31:0] killed_o
);

  logic [31:0] fetched_q, fetched_d;
  logic [31:0] killed_q, killed_d;

  always_comb begin
    fetched_d = fetched_q;
    killed_d  = killed_q;
    if (fetched_i) fetched_d = fetched_q + 32'd1;
    if (killed_i)  killed_d  = killed_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= '0;
      killed_q  <= '0;
    end else begin
      fetched_q <= fetched_d;
      killed_q  <= killed_d;
    end
  end

  assign fetched_o = fetched_q;
  assign killed_o  = killed_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the single-outstanding imem
// handshake and holds the fetched word for decode. Optional counters: FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000,
  parameter logic [31:0] NOP_INSTR    = fetch_unit_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] pcplus4_f,
  output logic        instr_valid_f,
  output logic        fetch_stall_req
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_killed
`endif
);

  import fetch_unit_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         req_en_q;
  logic         gnt;
  logic [31:0]  redirect_pc;

  // A grant only counts while we are actually requesting
  assign gnt         = imem_req & imem_gnt;
  assign redirect_pc = align_word(pc_target_e);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    imem_req = 1'b0;
    case (state_q)
      IDLE: begin
        imem_req = req_en_q;
        if (pc_src_e) begin
          pc_d    = redirect_pc;
          state_d = gnt ? KILL : IDLE;
        end else if (gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (pc_src_e) begin
          pc_d    = redirect_pc;
          state_d = imem_rvalid ? IDLE : KILL;
        end else if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = HELD;
        end
      end
      HELD: begin
        if (pc_src_e) begin
          pc_d    = redirect_pc;
          state_d = IDLE;
        end else if (!stall_f) begin
          pc_d    = pc_q + 32'd4;
          state_d = IDLE;
        end
      end
      KILL: begin
        if (pc_src_e) pc_d = redirect_pc;
        if (imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // req_en_q keeps imem_req low until the first edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= align_word(RESET_VECTOR);
      instr_q  <= NOP_INSTR;
      req_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      req_en_q <= 1'b1;
    end
  end

  assign imem_addr       = pc_q;
  assign pc_f            = pc_q;
  assign pcplus4_f       = pc_q + 32'd4;
  assign instr_valid_f   = (state_q == HELD);
  assign instr_f         = instr_valid_f ? instr_q : NOP_INSTR;
  assign fetch_stall_req = ~instr_valid_f;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && imem_rvalid && (state_q == IDLE || state_q == HELD))
      $error("fetch_unit: imem response with no request outstanding");
  end
`endif

`ifdef FETCH_PERF_CNT_EN
  logic ev_fetched;
  logic ev_killed;

  // Killed covers both a dropped wrong-path response and a flushed buffer
  assign ev_fetched = (state_q == HELD) & ~pc_src_e & ~stall_f;
  assign ev_killed  = ((state_q == HELD) & pc_src_e) |
                      (imem_rvalid & ((state_q == KILL) | ((state_q == WAIT) & pc_src_e)));

  fetch_perf_ctr u_perf (
    .clk       (clk),
    .rst       (rst),
    .fetched_i (ev_fetched),
    .killed_i  (ev_killed),
    .fetched_o (perf_fetched),
    .killed_o  (perf_killed)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the fetch stream.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] pcplus4_f;
  logic        instr_valid_f;
  logic        fetch_stall_req;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_killed;
`endif

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_VECTOR (32'h00000000),
    .NOP_INSTR    (NOP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_f         (stall_f),
    .pc_src_e        (pc_src_e),
    .pc_target_e     (pc_target_e),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr_f         (instr_f),
    .pc_f            (pc_f),
    .pcplus4_f       (pcplus4_f),
    .instr_valid_f   (instr_valid_f),
    .fetch_stall_req (fetch_stall_req)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_killed     (perf_killed)
`endif
  );

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: the next program-order PC, whether a good instruction
  // is being held, and the single memory transaction in flight.
  logic [31:0] expPc;
  logic        expValid;
  logic        outstanding;
  logic [31:0] outAddr;
  logic        outStale;
  int          expFetched;
  int          expKilled;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h00000010) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
  endtask

  task automatic resetModel();
    expPc       = 32'h00000000;
    expValid    = 1'b0;
    outstanding = 1'b0;
    outAddr     = 32'h0;
    outStale    = 1'b0;
    expFetched  = 0;
    expKilled   = 0;
  endtask

  task automatic checkAll();
    checkBit("instr_valid_f", instr_valid_f, expValid);
    checkBit("fetch_stall_req", fetch_stall_req, !expValid);
    checkOutput("pc_f", pc_f, expPc);
    checkOutput("pcplus4_f", pcplus4_f, expPc + 32'd4);
    checkOutput("instr_f", instr_f, expValid ? memWord(expPc) : NOP);
    checkBit("imem_req", imem_req, !expValid && !outstanding);
    if (imem_req) checkOutput("imem_addr", imem_addr, expPc);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("perf_fetched", perf_fetched, 32'(expFetched));
    checkOutput("perf_killed", perf_killed, 32'(expKilled));
`endif
  endtask

  task automatic idleInputs();
    stall_f     = 1'b0;
    pc_src_e    = 1'b0;
    pc_target_e = 32'h0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
  endtask

  // One clock: check at the negedge, drive, clock, advance the model
  task automatic applyStimulus(input logic stall, input logic redir, input logic [31:0] tgt,
                               input logic allowGnt, input logic allowRv);
    logic        g;
    logic        rv;
    logic        wasValid;
    logic [31:0] reqAddr;
    checkAll();
    stall_f     = stall;
    pc_src_e    = redir;
    pc_target_e = tgt;
    g           = allowGnt & imem_req;
    rv          = allowRv & outstanding;
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = outstanding ? memWord(outAddr) : $urandom;
    reqAddr     = imem_addr;
    wasValid    = expValid;
    @(posedge clk);
    if (wasValid) begin
      if (redir) begin
        expValid = 1'b0;
        expKilled++;
      end else if (!stall) begin
        expValid = 1'b0;
        expFetched++;
        expPc = expPc + 32'd4;
      end
    end
    if (outstanding && redir) outStale = 1'b1;
    if (rv) begin
      if (outStale) begin
        expKilled++;
      end else begin
        checkOutput("fetch_addr", outAddr, expPc);
        expValid = 1'b1;
      end
      outstanding = 1'b0;
    end
    if (g) begin
      checkBit("one_outstanding", outstanding, 1'b0);
      outstanding = 1'b1;
      outAddr     = reqAddr;
      outStale    = redir;
    end
    if (redir) expPc = tgt & ~32'd3;
    @(negedge clk);
  endtask

  task automatic asyncReset();
    idleInputs();
    #2 rst = 1'b1;
    resetModel();
    #1;
    checkBit("rst_imem_req", imem_req, 1'b0);
    checkBit("rst_valid", instr_valid_f, 1'b0);
    checkBit("rst_stall_req", fetch_stall_req, 1'b1);
    checkOutput("rst_instr_f", instr_f, NOP);
    checkOutput("rst_pc_f", pc_f, 32'h0);
    checkOutput("rst_pcplus4_f", pcplus4_f, 32'h4);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic runUntilValid(input logic stall, input int budget);
    for (int i = 0; i < budget && !expValid; i++) applyStimulus(stall, 1'b0, 32'h0, 1'b1, 1'b1);
    checkBit("reach_held", instr_valid_f, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    resetModel();
    @(negedge clk);
    asyncReset();

    // Straight-line fetches: 0x0, 0x4, 0x8 with immediate grant
    repeat (10) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Reset while a response is pending
    for (int i = 0; i < 4 && !outstanding; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    asyncReset();

    // Hold the instruction for 5 stalled cycles, then release
    runUntilValid(1'b1, 10);
    repeat (5) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Redirect in WAIT at 0x10 to unaligned 0x103; stale word must vanish
    runUntilValid(1'b1, 10);
    applyStimulus(1'b0, 1'b1, 32'h00000010, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h00000103, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    runUntilValid(1'b1, 10);

    // Redirect on the rvalid cycle, then redirect on the grant cycle
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h00000200, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h00000300, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Grant withheld for 4 cycles: address stable, bubble requested
    repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    runUntilValid(1'b0, 10);

    // PC wrap from the top of the address space
    applyStimulus(1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0);
    runUntilValid(1'b0, 10);
    repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(99, 0) < 30,
                    $urandom_range(99, 0) < 8,
                    $urandom,
                    $urandom_range(99, 0) < 60,
                    $urandom_range(99, 0) < 60);
    end

    checkAll();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that drives the F/D pipeline register's instruction, PC and PC+4 inputs. It owns the PC register and the instruction-memory request/response handshake, and holds the fetched instruction until decode accepts it. It applies execute-stage redirects, discarding in-flight responses on the wrong path. It tells the hazard unit when no valid instruction is available.

Parameters:
RESET_VECTOR, 32'h00000000, PC value after reset
NOP_INSTR, 32'h00000013, instruction presented when no valid fetch (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
stall_f  input  1  hazard unit hold; 1 = decode not accepting (F/D en low)
pc_src_e  input  1  redirect request from execute (taken branch/jump)
pc_target_e  input  32  redirect target
imem_req  output  1  instruction-memory request valid
imem_addr  output  32  request address, always word aligned
imem_gnt  input  1  memory accepted request this cycle
imem_rvalid  input  1  response valid (exactly one per granted request)
imem_rdata  input  32  response data
instr_f  output  32  instruction to F/D register (rd input)
pc_f  output  32  PC of instr_f
pcplus4_f  output  32  pc_f + 4
instr_valid_f  output  1  instr_f holds a real fetched instruction
fetch_stall_req  output  1  1 = no valid instruction; hazard unit inserts a bubble

Behaviour:
- Reset (async, any state): pc_q=RESET_VECTOR, state=IDLE, instr buffer=NOP_INSTR, instr_valid_f=0, imem_req=0 until first edge after deassertion.
- The PC register always holds the address of the next or in-flight fetch.
- Output pc_f=pc_q and pcplus4_f=pc_q+4. Both are 32-bit modulo; 0xFFFFFFFC+4 wraps to 0.
- Output instr_f is the buffer content when instr_valid_f=1, else NOP_INSTR.
- fetch_stall_req = !instr_valid_f.
- At most one outstanding request.
- FSM states: IDLE, WAIT, HELD, KILL.
- IDLE: imem_req=1, imem_addr=pc_q. On imem_gnt, go to WAIT.
- WAIT: imem_req=0. On imem_rvalid, capture imem_rdata, set instr_valid_f, go to HELD.
- HELD: outputs are stable. On !stall_f, pc_q<=pc_q+4, clear valid, go to IDLE. Minimum of 3 cycles per instruction.
- KILL: wait for the stale response. On imem_rvalid, drop the data and go to IDLE.
- Redirect (pc_src_e=1) has priority over stall_f in every state. pc_q<=pc_target_e with bits[1:0] forced to 0.
  - IDLE without gnt: go to IDLE.
  - IDLE with gnt in the same cycle: go to KILL.
  - WAIT without rvalid: go to KILL.
  - WAIT with rvalid in the same cycle: data dropped, go to IDLE.
  - HELD: buffer invalidated, go to IDLE.
  - KILL: pc_q updated, stay in KILL, or go to IDLE if rvalid arrives in the same cycle.
- A response arriving in IDLE or HELD is a protocol error. It is ignored, and under simulation only it triggers an $error.
- imem_addr is held constant while imem_req=1 and gnt is low, unless a redirect occurs.

Optional Feature:
FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched[31:0] (increments when an instruction leaves HELD on !stall_f without redirect) and perf_killed[31:0] (increments on each discarded response or invalidated buffer). Both reset to 0 and wrap at 2^32.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared pipeline package holds:
  - fetch state enum (IDLE=0, WAIT=1, HELD=2, KILL=3)
  - NOP_INSTR constant (shared with the F/D register's clear value)
  - XLEN=32
- No sub-module is needed for the core. Perf counters go in an optional small sub-module, fetch_perf_ctr, instantiated only under FETCH_PERF_CNT_EN.

Test Plan:
- Reset with rst=1 mid-WAIT, then release; memory gnt immediate, rvalid next cycle -> imem_addr=0x0, then 0x4, 0x8 in order; pc_f/pcplus4_f=0x0/0x4 with instr_valid_f=1; fetch_stall_req=0 only in HELD.
- stall_f=1 for 5 cycles in HELD -> instr_f, pc_f unchanged, no new imem_req; release -> next fetch at pc+4.
- In WAIT at pc=0x10, pc_src_e=1 with target 0x103 -> KILL; stale rdata 0xDEADBEEF is never presented; next request at 0x100.
- Redirect coinciding with rvalid, and redirect coinciding with gnt in IDLE -> no stale instr_valid_f; correct target fetched; exactly one response consumed per grant.
- gnt withheld for 4 cycles -> imem_addr stable, instr_f=0x00000013, fetch_stall_req=1 throughout.
- PC wrap: RESET_VECTOR=0xFFFFFFFC -> pcplus4_f=0x0, next fetch address 0x0; with FETCH_PERF_CNT_EN, perf counters match fetched/killed counts.
